ulas_ctrl_seq: RTL

ULAS_CTRL_SEQ -- requirements
Module: ulas_ctrl_seq

---
 rtl/ulas_ctrl_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ulas_ctrl_seq.sv
// MIPS-subset control sequencer: decodes one instruction per handshake and presents the
// ALU/datapath controls for one cycle, or holds them MULDIV_CYCLES cycles for MULT/DIV.
module ulas_ctrl_seq #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   input  logic        uf,
   output logic [4:0]  aluop,
   output logic [4:0]  smt,
   output logic [31:0] imm_ext,
   output logic        use_imm,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        ctrl_valid,
   output logic        branch_taken,
   output logic        illegal,
   output logic        busy
);

   localparam int CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MULDIV_CYCLES - 2);

   typedef enum logic [1:0] {IDLE, ISSUE, MDWAIT} state_t;

   typedef struct packed {
      logic [4:0]  aluop;
      logic [4:0]  smt;
      logic [31:0] imm_ext;
      logic        use_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        is_md;
      logic        bad;
   } dec_t;

   state_t          state_q, state_d;
   dec_t            dec_q, dec_d, dec_w;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            bt_q, bt_d;
   logic            hs;

   logic [5:0]  opcode, funct;
   logic [31:0] sext, zext;
   logic        unused_rs_rt;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   assign sext         = {{16{instr[15]}}, instr[15:0]};
   assign zext         = {16'h0000, instr[15:0]};
   assign unused_rs_rt = ^instr[25:16];

   always_comb begin
      dec_w = '0;
      if (opcode == 6'h00) begin
         dec_w.reg_write = 1'b1;
         case (funct)
            6'h20: dec_w.aluop = 5'b00001;
            6'h22: dec_w.aluop = 5'b00010;
            6'h24: dec_w.aluop = 5'b00011;
            6'h25: dec_w.aluop = 5'b00100;
            6'h27: dec_w.aluop = 5'b00101;
            6'h26: dec_w.aluop = 5'b00110;
            6'h00: begin
               dec_w.aluop = 5'b00111;
               dec_w.smt   = instr[10:6];
            end
            6'h02: begin
               dec_w.aluop = 5'b01000;
               dec_w.smt   = instr[10:6];
            end
            6'h2A: dec_w.aluop = 5'b01001;
            6'h18: begin
               dec_w.aluop     = 5'b10000;
               dec_w.reg_write = 1'b0;
               dec_w.is_md     = 1'b1;
            end
            6'h1A: begin
               dec_w.aluop     = 5'b10001;
               dec_w.reg_write = 1'b0;
               dec_w.is_md     = 1'b1;
            end
            default: dec_w.bad = 1'b1;
         endcase
      end else begin
         dec_w.use_imm   = 1'b1;
         dec_w.reg_write = 1'b1;
         case (opcode)
            6'h08: begin dec_w.aluop = 5'b00001; dec_w.imm_ext = sext; end
            6'h0C: begin dec_w.aluop = 5'b00011; dec_w.imm_ext = zext; end
            6'h0D: begin dec_w.aluop = 5'b00100; dec_w.imm_ext = zext; end
            6'h0E: begin dec_w.aluop = 5'b00110; dec_w.imm_ext = zext; end
            6'h0A: begin dec_w.aluop = 5'b01001; dec_w.imm_ext = sext; end
            6'h0F: begin dec_w.aluop = 5'b01111; dec_w.imm_ext = zext; end
            6'h04, 6'h05: begin
               dec_w.aluop     = (opcode == 6'h04) ? 5'b01011 : 5'b01100;
               dec_w.imm_ext   = sext;
               dec_w.branch    = 1'b1;
               dec_w.reg_write = 1'b0;
            end
            6'h23: begin
               dec_w.aluop    = 5'b00001;
               dec_w.imm_ext  = sext;
               dec_w.mem_read = 1'b1;
            end
            6'h2B: begin
               dec_w.aluop     = 5'b00001;
               dec_w.imm_ext   = sext;
               dec_w.mem_write = 1'b1;
               dec_w.reg_write = 1'b0;
            end
            default: dec_w.bad = 1'b1;
         endcase
      end
      // An undecodable word must carry no controls at all, only the flag.
      if (dec_w.bad) begin
         dec_w     = '0;
         dec_w.bad = 1'b1;
      end
   end

   // Ready is forced low while reset is held so every output reads zero.
   assign instr_ready = rst_n & ((state_q == IDLE) | ((state_q == ISSUE) & ~dec_q.is_md));
   assign hs          = instr_valid & instr_ready;

   always_comb begin
      state_d    = state_q;
      dec_d      = dec_q;
      cnt_d      = cnt_q;
      bt_d       = 1'b0;
      aluop      = 5'b00000;
      smt        = 5'b00000;
      imm_ext    = 32'h0000_0000;
      use_imm    = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      ctrl_valid = 1'b0;
      illegal    = 1'b0;
      busy       = 1'b0;
      if (hs) begin
         dec_d = dec_w;
      end
      case (state_q)
         IDLE: begin
            if (hs) state_d = ISSUE;
         end
         ISSUE: begin
            if (dec_q.is_md) begin
               busy    = 1'b1;
               aluop   = dec_q.aluop;
               cnt_d   = CNT_INIT;
               state_d = MDWAIT;
            end else begin
               if (dec_q.bad) begin
                  illegal = 1'b1;
               end else begin
                  aluop      = dec_q.aluop;
                  smt        = dec_q.smt;
                  imm_ext    = dec_q.imm_ext;
                  use_imm    = dec_q.use_imm;
                  reg_write  = dec_q.reg_write;
                  mem_read   = dec_q.mem_read;
                  mem_write  = dec_q.mem_write;
                  branch     = dec_q.branch;
                  ctrl_valid = 1'b1;
                  bt_d       = dec_q.branch & uf;
               end
               state_d = hs ? ISSUE : IDLE;
            end
         end
         MDWAIT: begin
            busy  = 1'b1;
            aluop = dec_q.aluop;
            if (cnt_q == '0) begin
               ctrl_valid = 1'b1;
               reg_write  = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign branch_taken = bt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dec_q   <= '0;
         cnt_q   <= '0;
         bt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dec_q   <= dec_d;
         cnt_q   <= cnt_d;
         bt_q    <= bt_d;
      end
   end

endmodule
